vec_burst_reader: RTL and testbench
===================================

Name: vec_burst_reader

Overview:
- Parametrised AXI4 read engine for the PageRank accelerator.
- Software programs a base address and a line count over softreg, then starts a run. The block fetches 64-byte lines as multi-beat bursts, with several bursts outstanding, and streams them downstream through a valid/ready interface.
- An internal FIFO decouples memory from the consumer. Software polls a status register for done, error and a delivered-line count.

Parameters:
- DATA_W, 512, AXI data width in bits (one line per beat)
- ID_W, 16, AXI ID width; the block always drives ID 0
- MAX_BURST, 8, maximum beats per AR request (1..256)
- FIFO_DEPTH, 32, output FIFO entries; power of 2, >= MAX_BURST
- MAX_OUTSTANDING, 4, maximum AR requests in flight

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- arid_m  out  ID_W  read ID, constant 0
- araddr_m  out  64  burst start address, 64B aligned
- arlen_m  out  8  beats minus 1
- arsize_m  out  3  constant 3'b110
- arvalid_m  out  1  AR valid
- arready_m  in  1  AR ready
- rdata_m  in  DATA_W  read data
- rresp_m  in  2  read response
- rlast_m  in  1  last beat of burst
- rvalid_m  in  1  R valid
- rready_m  out  1  R ready
- softreg_req_valid  in  1  softreg request
- softreg_req_isWrite  in  1  1 = write
- softreg_req_addr  in  32  register address
- softreg_req_data  in  64  write data
- softreg_resp_valid  out  1  read response valid
- softreg_resp_data  out  64  read response data
- out_data  out  DATA_W  streamed line
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- busy  out  1  run in progress

Behaviour:
- Registers:
  - 0x00 BASE (W): address bits [5:0] forced to 0.
  - 0x08 COUNT (W): lines, 32 bits used.
  - 0x10 START (W, data ignored).
  - 0x18 STATUS (R): bit0 done, bit1 err, bits[63:32] lines delivered.
  - 0x20 CYCLES (R).
- Softreg reads: resp_valid exactly 1 cycle after a read request. Unmapped addresses return 0.
- Writes to BASE/COUNT while busy are ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - START in IDLE or DONE: clear done/err/delivered, load cur_addr=BASE, remaining=COUNT.
  - Then go to ISSUE, or to DONE the next cycle if COUNT==0 (no AR issued).
  - START in ISSUE/DRAIN is ignored.
- Burst sizing: len = min(MAX_BURST, remaining, lines left to the next 4KB boundary). Bursts never cross 4KB.
- AR issue requires all of:
  - outstanding < MAX_OUTSTANDING;
  - FIFO free entries minus beats already requested but not received >= len.
- AR handshake:
  - arvalid_m, araddr_m and arlen_m hold stable until arready_m.
  - On handshake: cur_addr += len*64, remaining -= len.
  - When remaining reaches 0, go to DRAIN.
- rready_m = 1 whenever not in reset. The credit rule guarantees FIFO space for every beat.
- Each accepted R beat is pushed to the FIFO. rlast_m decrements outstanding.
- A simultaneous AR handshake and rlast leaves outstanding unchanged.
- rresp_m != 0 sets sticky err. The data is still pushed.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head (first-word-fall-through).
  - A pop on out_valid & out_ready increments delivered.
- DRAIN to DONE when outstanding==0 and the FIFO is empty. done=1 and busy=0 in DONE.
- busy = 1 in ISSUE and DRAIN.
- Reset (including mid-run): state IDLE, all outputs 0 except arsize_m, FIFO emptied, counters/flags 0, BASE/COUNT 0.
  - Any R beats still in flight after reset are accepted and dropped while in IDLE.
- COUNT up to 2^32-1; remaining is 32-bit; address arithmetic is 64-bit wrap.

Optional Feature:
- Macro VBR_PERF_CNT_EN.
- Defined: a 64-bit CYCLES counter clears on accepted START, increments every cycle in ISSUE/DRAIN, freezes in DONE, and reads at 0x20.
- Undefined: no counter logic; 0x20 reads 0.

Test Plan:
- BASE=0x1000, COUNT=1, START → one AR (addr 0x1000, arlen 0), one out beat; STATUS reads 0x0000_0001_0000_0001.
- COUNT=20, MAX_BURST=8, BASE=0x0 → ARs arlen 7,7,3 at 0x0, 0x200, 0x400; 20 beats out in order; done=1.
- BASE=0xFC0, COUNT=4 → AR addr 0xFC0 arlen 0, then AR addr 0x1000 arlen 2; no burst crosses 4KB.
- COUNT=64, out_ready held 0 → at most FIFO_DEPTH beats requested, then no new AR. Release out_ready → all 64 lines delivered, none lost or duplicated.
- COUNT=0, START → no arvalid_m; done=1 within 2 cycles; delivered=0.
- rresp_m=2'b10 on beat 3 of 8 → err=1, all 8 beats delivered. Assert rst mid-run → busy=0, out_valid=0, STATUS reads 0.

Source files
------------

// File: rtl/vec_burst_reader_if.sv
// Purpose: bundles the AXI4 read channels, softreg port and output stream of vec_burst_reader.
// Latency: none; this is wiring only.
// Backpressure: carries arready_m, rready_m and out_ready; the handshake rules live in the engine.
interface vec_burst_reader_if #(
    parameter int DATA_W = 512,
    parameter int ID_W   = 16
);
    // AXI4 read address channel
    logic [ID_W-1:0]   arid_m;
    logic [63:0]       araddr_m;
    logic [7:0]        arlen_m;
    logic [2:0]        arsize_m;
    logic              arvalid_m;
    logic              arready_m;
    // AXI4 read data channel
    logic [DATA_W-1:0] rdata_m;
    logic [1:0]        rresp_m;
    logic              rlast_m;
    logic              rvalid_m;
    logic              rready_m;
    // softreg access
    logic              softreg_req_valid;
    logic              softreg_req_isWrite;
    logic [31:0]       softreg_req_addr;
    logic [63:0]       softreg_req_data;
    logic              softreg_resp_valid;
    logic [63:0]       softreg_resp_data;
    // line stream
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    // engine side
    modport master (
        output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
        input  arready_m,
        input  rdata_m, rresp_m, rlast_m, rvalid_m,
        output rready_m,
        input  softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        output softreg_resp_valid, softreg_resp_data,
        output out_data, out_valid,
        input  out_ready,
        output busy
    );

    // memory / host / consumer side
    modport slave (
        input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
        output arready_m,
        output rdata_m, rresp_m, rlast_m, rvalid_m,
        input  rready_m,
        output softreg_req_valid, softreg_req_isWrite, softreg_req_addr, softreg_req_data,
        input  softreg_resp_valid, softreg_resp_data,
        input  out_data, out_valid,
        output out_ready,
        input  busy
    );
endinterface

// File: rtl/vec_burst_reader.sv
// Purpose: AXI4 burst read engine; fetches COUNT 64B lines from BASE and streams them out (optional CYCLES counter: VBR_PERF_CNT_EN).
// Latency: softreg read response 1 cycle; lines appear on out_* one cycle after their R beat is accepted.
// Backpressure: out_ready stalls the FIFO; ARs are only issued when FIFO space covers every requested beat, so rready_m never drops.
module vec_burst_reader #(
    parameter int DATA_W          = 512,
    parameter int ID_W            = 16,
    parameter int MAX_BURST       = 8,
    parameter int FIFO_DEPTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    vec_burst_reader_if.master vbr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_busy;

    // programmed configuration and run bookkeeping
    logic [63:0] r_base;
    logic [31:0] r_count;
    logic [63:0] r_cur_addr;
    logic [31:0] r_remaining;
    logic [31:0] r_outstanding;
    logic [31:0] r_pending;
    logic        r_err;
    logic [31:0] r_delivered;

    // registered AR request, held until arready_m
    logic        r_arvalid;
    logic [63:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [31:0] r_ar_beats;

    // output FIFO
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       w_fill;
    logic              w_empty;

    logic        r_resp_valid;
    logic [63:0] r_resp_data;
    logic [63:0] w_rd_data;
    logic [63:0] w_cycles;

    logic        w_wr;
    logic        w_rd;
    logic        w_start_acc;
    logic        w_r_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_ar_hs;
    logic        w_issue;
    logic [6:0]  w_to_4k;
    logic [31:0] w_len;
    logic [33:0] w_need;

    assign w_wr        = vbr.softreg_req_valid & vbr.softreg_req_isWrite;
    assign w_rd        = vbr.softreg_req_valid & ~vbr.softreg_req_isWrite;
    assign w_start_acc = w_wr && (vbr.softreg_req_addr == 32'h10)
                         && (r_state == S_IDLE || r_state == S_DONE);

    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_fill == '0);
    // beats landing in IDLE are leftovers from a run cut short by reset
    assign w_r_acc = vbr.rvalid_m & vbr.rready_m;
    assign w_push  = w_r_acc && (r_state != S_IDLE);
    assign w_pop   = ~w_empty & vbr.out_ready;
    assign w_ar_hs = r_arvalid & vbr.arready_m;

    assign w_to_4k = 7'd64 - {1'b0, r_cur_addr[11:6]};

    // next burst length: smallest of burst cap, lines left, lines to the 4KB page end
    always_comb begin
        w_len = 32'(MAX_BURST);
        if (r_remaining < w_len) begin
            w_len = r_remaining;
        end
        if ({25'd0, w_to_4k} < w_len) begin
            w_len = {25'd0, w_to_4k};
        end
    end

    // every beat already in the FIFO or still owed by memory must fit alongside the new burst
    assign w_need  = 34'(w_fill) + 34'(r_pending) + 34'(w_len);
    assign w_issue = (r_state == S_ISSUE) && !r_arvalid && (r_remaining != 32'd0)
                     && (r_outstanding < 32'(MAX_OUTSTANDING))
                     && (w_need <= 34'(FIFO_DEPTH));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and busy flag
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_acc) begin
                    w_state_nxt = (r_count == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_busy = 1'b1;
                if (w_ar_hs && (r_remaining == r_ar_beats)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if ((r_outstanding == 32'd0) && w_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // BASE/COUNT registers, frozen while a run is in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_count <= '0;
        end else if (w_wr && !w_busy) begin
            if (vbr.softreg_req_addr == 32'h00) begin
                r_base <= {vbr.softreg_req_data[63:6], 6'd0};
            end
            if (vbr.softreg_req_addr == 32'h08) begin
                r_count <= vbr.softreg_req_data[31:0];
            end
        end
    end

    // AR request: captured once credit allows, held stable until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_ar_beats <= '0;
        end else if (w_ar_hs) begin
            r_arvalid <= 1'b0;
        end else if (w_issue) begin
            r_arvalid  <= 1'b1;
            r_araddr   <= r_cur_addr;
            r_arlen    <= 8'(w_len - 32'd1);
            r_ar_beats <= w_len;
        end
    end

    // walk the address window as each burst is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else if (w_start_acc) begin
            r_cur_addr  <= r_base;
            r_remaining <= r_count;
        end else if (w_ar_hs) begin
            r_cur_addr  <= r_cur_addr + (64'(r_ar_beats) << 6);
            r_remaining <= r_remaining - r_ar_beats;
        end
    end

    // outstanding bursts and owed beats; a same-cycle AR and rlast cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_pending     <= '0;
        end else begin
            r_outstanding <= r_outstanding + 32'(w_ar_hs) - 32'(w_push & vbr.rlast_m);
            r_pending     <= r_pending + (w_ar_hs ? r_ar_beats : 32'd0) - 32'(w_push);
        end
    end

    // sticky error and delivered-line count, both cleared by START
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err       <= 1'b0;
            r_delivered <= '0;
        end else if (w_start_acc) begin
            r_err       <= 1'b0;
            r_delivered <= '0;
        end else begin
            if (w_push && (vbr.rresp_m != 2'b00)) begin
                r_err <= 1'b1;
            end
            if (w_pop) begin
                r_delivered <= r_delivered + 32'd1;
            end
        end
    end

    // FIFO storage, no reset needed since empty pointers mask it
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= vbr.rdata_m;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef VBR_PERF_CNT_EN
    logic [63:0] r_cycles;

    // run-length counter: restarts on START, stops once the run is done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (w_start_acc) begin
            r_cycles <= '0;
        end else if (w_busy) begin
            r_cycles <= r_cycles + 64'd1;
        end
    end
    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    // softreg read mux; unmapped and write-only addresses read 0
    always_comb begin
        w_rd_data = '0;
        case (vbr.softreg_req_addr)
            32'h18:  w_rd_data = {r_delivered, 30'd0, r_err, (r_state == S_DONE)};
            32'h20:  w_rd_data = w_cycles;
            default: w_rd_data = '0;
        endcase
    end

    // softreg response, one cycle after the read request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= w_rd;
            r_resp_data  <= w_rd ? w_rd_data : 64'd0;
        end
    end

    assign vbr.arid_m             = '0;
    assign vbr.araddr_m           = r_araddr;
    assign vbr.arlen_m            = r_arlen;
    assign vbr.arsize_m           = 3'b110;
    assign vbr.arvalid_m          = r_arvalid;
    assign vbr.rready_m           = ~rst;
    assign vbr.softreg_resp_valid = r_resp_valid;
    assign vbr.softreg_resp_data  = r_resp_data;
    assign vbr.out_valid          = ~w_empty;
    assign vbr.out_data           = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign vbr.busy               = w_busy;

endmodule

// File: tb/tb_vec_burst_reader.sv
// Purpose: directed bench for vec_burst_reader with an AXI read-memory model and stream monitor.
// Latency: memory answers an AR on the following cycle, one beat per cycle.
// Backpressure: arready toggles every cycle; out_ready is driven by the directed steps.
module tb_vec_burst_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_burst_reader_if #(.DATA_W(512), .ID_W(16)) vif ();

    vec_burst_reader #(
        .DATA_W(512), .ID_W(16), .MAX_BURST(8), .FIFO_DEPTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vbr (vif.master)
    );

    int checks = 0;
    int errors = 0;

    // memory model state
    logic [63:0]  q_addr[$];
    logic [7:0]   q_len[$];
    logic [63:0]  ar_addr_log[$];
    logic [7:0]   ar_len_log[$];
    int           beat_in_burst = 0;
    int           beat_total = 0;
    int           err_beat = -1;
    int           hold_viol = 0;
    logic [511:0] out_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI read slave: logs ARs, answers each burst in order with data = line address
    initial begin
        logic        ar_fire, r_fire, pend_hold;
        logic [63:0] h_addr, a;
        logic [7:0]  h_len;
        pend_hold = 1'b0;
        h_addr = '0;
        h_len = '0;
        vif.arready_m = 1'b0;
        vif.rvalid_m  = 1'b0;
        vif.rdata_m   = '0;
        vif.rresp_m   = 2'b00;
        vif.rlast_m   = 1'b0;
        forever begin
            @(negedge clk);
            ar_fire = vif.arvalid_m && vif.arready_m;
            r_fire  = vif.rvalid_m && vif.rready_m;
            if (rst) begin
                pend_hold = 1'b0;
            end else begin
                if (pend_hold && !(vif.arvalid_m && vif.araddr_m == h_addr && vif.arlen_m == h_len))
                    hold_viol++;
                pend_hold = vif.arvalid_m && !vif.arready_m;
                h_addr = vif.araddr_m;
                h_len  = vif.arlen_m;
            end
            if (ar_fire) begin
                q_addr.push_back(vif.araddr_m);
                q_len.push_back(vif.arlen_m);
                ar_addr_log.push_back(vif.araddr_m);
                ar_len_log.push_back(vif.arlen_m);
            end
            @(posedge clk);
            #1;
            if (r_fire) begin
                beat_total++;
                if (beat_in_burst == int'(q_len[0])) begin
                    void'(q_addr.pop_front());
                    void'(q_len.pop_front());
                    beat_in_burst = 0;
                end else begin
                    beat_in_burst++;
                end
            end
            vif.arready_m = ~vif.arready_m;
            if (q_addr.size() > 0) begin
                a = q_addr[0] + 64'(beat_in_burst) * 64;
                vif.rvalid_m = 1'b1;
                vif.rdata_m  = {8{a}};
                vif.rlast_m  = (beat_in_burst == int'(q_len[0]));
                vif.rresp_m  = (beat_total == err_beat) ? 2'b10 : 2'b00;
            end else begin
                vif.rvalid_m = 1'b0;
                vif.rlast_m  = 1'b0;
                vif.rresp_m  = 2'b00;
            end
        end
    end

    // stream monitor: records every line popped from the engine
    initial begin
        forever begin
            @(negedge clk);
            if (vif.out_valid && vif.out_ready) out_q.push_back(vif.out_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic sr_write(input logic [31:0] addr, input logic [63:0] data);
        vif.softreg_req_valid   = 1'b1;
        vif.softreg_req_isWrite = 1'b1;
        vif.softreg_req_addr    = addr;
        vif.softreg_req_data    = data;
        @(posedge clk);
        #1;
        vif.softreg_req_valid   = 1'b0;
        vif.softreg_req_isWrite = 1'b0;
    endtask

    task automatic sr_read(input logic [31:0] addr, output logic [63:0] data);
        vif.softreg_req_valid   = 1'b1;
        vif.softreg_req_isWrite = 1'b0;
        vif.softreg_req_addr    = addr;
        @(posedge clk);
        #1;
        vif.softreg_req_valid   = 1'b0;
        @(negedge clk);
        chk("resp_valid", 64'(vif.softreg_resp_valid), 64'd1);
        data = vif.softreg_resp_data;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (vif.busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(n >= budget), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input logic [63:0] base, input int n, input string tag);
        int bad;
        bad = 0;
        chk({tag, "_count"}, 64'(out_q.size()), 64'(n));
        foreach (out_q[i]) begin
            if (out_q[i] !== {8{base + 64'(i) * 64}}) bad++;
        end
        chk({tag, "_data"}, 64'(bad), 64'd0);
    endtask

    task automatic run(input logic [63:0] base, input logic [31:0] cnt, output int mark);
        sr_write(32'h00, base);
        sr_write(32'h08, {32'd0, cnt});
        out_q.delete();
        mark = ar_addr_log.size();
        sr_write(32'h10, 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        int          mark;
        int          beats;

        rst = 1'b1;
        vif.softreg_req_valid   = 1'b0;
        vif.softreg_req_isWrite = 1'b0;
        vif.softreg_req_addr    = '0;
        vif.softreg_req_data    = '0;
        vif.out_ready           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", 64'(vif.arvalid_m), 64'd0);
        chk("rst_araddr", vif.araddr_m, 64'd0);
        chk("rst_arsize", 64'(vif.arsize_m), 64'd6);
        chk("rst_rready", 64'(vif.rready_m), 64'd0);
        chk("rst_out_valid", 64'(vif.out_valid), 64'd0);
        chk("rst_busy", 64'(vif.busy), 64'd0);
        chk("rst_resp_valid", 64'(vif.softreg_resp_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rready_after_rst", 64'(vif.rready_m), 64'd1);
        chk("arid", 64'(vif.arid_m), 64'd0);
        @(posedge clk);
        #1;
        sr_read(32'h18, d);
        chk("status_reset", d, 64'd0);

        // single line; low address bits written as ones must be dropped
        run(64'h103F, 32'd1, mark);
        wait_idle(500, "t1");
        chk("t1_ar_count", 64'(ar_addr_log.size() - mark), 64'd1);
        chk("t1_ar_addr", ar_addr_log[mark], 64'h1000);
        chk("t1_ar_len", 64'(ar_len_log[mark]), 64'd0);
        check_stream(64'h1000, 1, "t1_stream");
        sr_read(32'h18, d);
        chk("t1_status", d, 64'h0000_0001_0000_0001);
`ifndef VBR_PERF_CNT_EN
        sr_read(32'h20, d);
        chk("cycles_absent", d, 64'd0);
`endif

        // 20 lines split 8/8/4
        run(64'h0, 32'd20, mark);
        wait_idle(1000, "t2");
        chk("t2_ar_count", 64'(ar_addr_log.size() - mark), 64'd3);
        chk("t2_ar0_addr", ar_addr_log[mark], 64'h0);
        chk("t2_ar0_len", 64'(ar_len_log[mark]), 64'd7);
        chk("t2_ar1_addr", ar_addr_log[mark + 1], 64'h200);
        chk("t2_ar1_len", 64'(ar_len_log[mark + 1]), 64'd7);
        chk("t2_ar2_addr", ar_addr_log[mark + 2], 64'h400);
        chk("t2_ar2_len", 64'(ar_len_log[mark + 2]), 64'd3);
        check_stream(64'h0, 20, "t2_stream");
        sr_read(32'h18, d);
        chk("t2_status", d, 64'h0000_0014_0000_0001);

        // 4KB boundary split
        run(64'hFC0, 32'd4, mark);
        wait_idle(1000, "t3");
        chk("t3_ar_count", 64'(ar_addr_log.size() - mark), 64'd2);
        chk("t3_ar0_addr", ar_addr_log[mark], 64'hFC0);
        chk("t3_ar0_len", 64'(ar_len_log[mark]), 64'd0);
        chk("t3_ar1_addr", ar_addr_log[mark + 1], 64'h1000);
        chk("t3_ar1_len", 64'(ar_len_log[mark + 1]), 64'd2);
        check_stream(64'hFC0, 4, "t3_stream");

        // zero-length run: done without any AR; STATUS read right after START
        sr_write(32'h08, 64'd0);
        out_q.delete();
        mark = ar_addr_log.size();
        sr_write(32'h10, 64'd0);
        sr_read(32'h18, d);
        chk("t5_status", d, 64'h0000_0000_0000_0001);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_ar_count", 64'(ar_addr_log.size() - mark), 64'd0);
        chk("t5_out_count", 64'(out_q.size()), 64'd0);

        // error response on the third beat of an 8-beat burst
        err_beat = beat_total + 2;
        run(64'h3000, 32'd8, mark);
        wait_idle(1000, "t6");
        err_beat = -1;
        check_stream(64'h3000, 8, "t6_stream");
        sr_read(32'h18, d);
        chk("t6_status", d, 64'h0000_0008_0000_0003);

        // consumer stalled: credit limits requests to the FIFO depth
        vif.out_ready = 1'b0;
        run(64'h2000, 32'd64, mark);
        repeat (200) @(posedge clk);
        #1;
        beats = 0;
        for (int i = mark; i < ar_addr_log.size(); i++) beats += int'(ar_len_log[i]) + 1;
        chk("t4_beats_requested", 64'(beats), 64'd32);
        chk("t4_ar_count_stalled", 64'(ar_addr_log.size() - mark), 64'd4);
        chk("t4_busy", 64'(vif.busy), 64'd1);
        sr_write(32'h00, 64'h7000);
        vif.out_ready = 1'b1;
        wait_idle(2000, "t4");
        chk("t4_ar_count", 64'(ar_addr_log.size() - mark), 64'd8);
        check_stream(64'h2000, 64, "t4_stream");
        sr_write(32'h08, 64'd1);
        mark = ar_addr_log.size();
        sr_write(32'h10, 64'd0);
        wait_idle(500, "t4b");
        chk("t4_base_kept", ar_addr_log[mark], 64'h2000);

        sr_read(32'h28, d);
        chk("unmapped_read", d, 64'd0);

        // reset in the middle of a stalled run
        vif.out_ready = 1'b0;
        run(64'h4000, 32'd64, mark);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mr_busy", 64'(vif.busy), 64'd0);
        chk("mr_out_valid", 64'(vif.out_valid), 64'd0);
        chk("mr_arvalid", 64'(vif.arvalid_m), 64'd0);
        vif.out_ready = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("mr_slave_drained", 64'(q_addr.size()), 64'd0);
        chk("mr_dropped", 64'(vif.out_valid), 64'd0);
        sr_read(32'h18, d);
        chk("mr_status", d, 64'd0);
        // BASE/COUNT were cleared, so a bare START is a zero-length run
        mark = ar_addr_log.size();
        sr_write(32'h10, 64'd0);
        sr_read(32'h18, d);
        chk("mr_restart_status", d, 64'd1);
        chk("mr_restart_no_ar", 64'(ar_addr_log.size() - mark), 64'd0);

        chk("ar_hold_stable", 64'(hold_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
